// File: rtl/scan_index_gen.sv
// Index generator for a 4-to-16 decoder, with a prescaled step and run/pause/idle control.
// Latency: A/tick/wrap update on the step edge, DIV clk after entering RUN. No backpressure; stop beats start.
// Optional `SCAN_BLINK_EN: EN blinks every DIV cycles while paused.
module scan_index_gen #(
    parameter int DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic [3:0] A,
    output logic       EN,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] pre;
    logic          dir;       // 1 = counting down
    logic          pre_last;
    logic [3:0]    a_nxt;
    logic          dir_nxt;
    logic          wrap_nxt;
    logic          eff_dir;

    assign pre_last = (pre == PMAX);

    always_comb begin
        a_nxt    = A;
        dir_nxt  = dir;
        wrap_nxt = 1'b0;
        eff_dir  = dir;
        case (mode)
            2'b00: begin
                a_nxt    = A + 4'd1;
                wrap_nxt = (A == 4'hF);
            end
            2'b01: begin
                a_nxt    = A - 4'd1;
                wrap_nxt = (A == 4'h0);
            end
            2'b10: begin
                // An endpoint always points inward, even when arriving from up/down/hold mode.
                eff_dir  = (A == 4'hF) ? 1'b1 : (A == 4'h0) ? 1'b0 : dir;
                a_nxt    = eff_dir ? (A - 4'd1) : (A + 4'd1);
                wrap_nxt = (a_nxt == 4'hF) || (a_nxt == 4'h0);
                dir_nxt  = (a_nxt == 4'hF) ? 1'b1 : (a_nxt == 4'h0) ? 1'b0 : eff_dir;
            end
            default: begin
                a_nxt    = A;
                wrap_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            A     <= 4'h0;
            EN    <= 1'b0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
            pre   <= '0;
            dir   <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state <= RUN;
                        A     <= (mode == 2'b01) ? 4'hF : 4'h0;
                        dir   <= (mode == 2'b01);
                        pre   <= '0;
                        EN    <= 1'b1;
                    end
                end
                RUN: begin
                    // A stop on a would-be step edge swallows that step entirely.
                    if (stop) begin
                        state <= PAUSE;
                        pre   <= '0;
                    end else if (pre_last) begin
                        pre  <= '0;
                        tick <= 1'b1;
                        wrap <= wrap_nxt;
                        A    <= a_nxt;
                        dir  <= dir_nxt;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state <= IDLE;
                        A     <= 4'h0;
                        EN    <= 1'b0;
                        pre   <= '0;
                    end else if (start) begin
                        state <= RUN;
                        pre   <= '0;
                        EN    <= 1'b1;
                    end
`ifdef SCAN_BLINK_EN
                    else if (pre_last) begin
                        pre <= '0;
                        EN  <= ~EN;
                    end else begin
                        pre <= pre + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    A     <= 4'h0;
                    EN    <= 1'b0;
                    pre   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen at DIV=4; expected values are hand-derived per step.
module tb_scan_index_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] A;
    logic       EN;
    logic       tick;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    scan_index_gen #(.DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .A     (A),
        .EN    (EN),
        .tick  (tick),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full DIV=4 step: three quiet cycles at pa, then the tick edge landing on na.
    task automatic step(input logic [3:0] pa, input logic [3:0] na, input logic w);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("hold_A", A, pa);
            chk("tick_lo", tick, 1'b0);
            chk("wrap_lo", wrap, 1'b0);
        end
        cyc();
        chk("step_A", A, na);
        chk("tick_hi", tick, 1'b1);
        chk("wrap", wrap, w);
    endtask

    logic en_exp;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
        repeat (3) cyc();
        chk("rst_A", A, 4'h0);
        chk("rst_EN", EN, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        rst = 1'b0;
        cyc();
        chk("idle_EN", EN, 1'b0);

        // 1: up count through the 15->0 wrap
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_EN", EN, 1'b1);
        chk("t1_A0", A, 4'h0);
        chk("t1_tick0", tick, 1'b0);
        for (int s = 1; s <= 16; s++)
            step(4'(s - 1), 4'(s % 16), s == 16);

        // 2: ping-pong through both endpoints
        for (int a = 0; a < 13; a++) step(4'(a), 4'(a + 1), 1'b0);
        mode = 2'b10;
        step(4'd13, 4'd14, 1'b0);
        step(4'd14, 4'd15, 1'b1);
        step(4'd15, 4'd14, 1'b0);
        for (int a = 14; a >= 1; a--) step(4'(a), 4'(a - 1), a == 1);
        step(4'd0, 4'd1, 1'b0);

        // back to IDLE, then 3: down count from 15
        stop = 1'b1; cyc(); cyc(); stop = 1'b0;
        chk("t3_idle_A", A, 4'h0);
        chk("t3_idle_EN", EN, 1'b0);
        mode = 2'b01;
        start = 1'b1; cyc(); start = 1'b0;
        chk("t3_load_A", A, 4'hF);
        chk("t3_EN", EN, 1'b1);
        step(4'd15, 4'd14, 1'b0);
        for (int a = 14; a >= 1; a--) step(4'(a), 4'(a - 1), 1'b0);
        step(4'd0, 4'd15, 1'b1);

        // 4: pause at 6 on the would-be tick edge, resume, stop twice
        mode = 2'b00;
        step(4'd15, 4'd0, 1'b1);
        for (int a = 0; a < 6; a++) step(4'(a), 4'(a + 1), 1'b0);
        repeat (3) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t4_sup_tick", tick, 1'b0);
        chk("t4_sup_A", A, 4'd6);
        chk("t4_pause_EN", EN, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cyc();
`ifdef SCAN_BLINK_EN
            en_exp = ((i / 4) % 2 == 0);
`else
            en_exp = 1'b1;
`endif
            chk("t4_pause_A", A, 4'd6);
            chk("t4_pause_tick", tick, 1'b0);
            chk("t4_pause_EN", EN, en_exp);
        end
        start = 1'b1; cyc(); start = 1'b0;
        chk("t4_resume_A", A, 4'd6);
        chk("t4_resume_EN", EN, 1'b1);
        step(4'd6, 4'd7, 1'b0);
        stop = 1'b1; cyc(); cyc(); stop = 1'b0;
        chk("t4_idle_A", A, 4'h0);
        chk("t4_idle_EN", EN, 1'b0);

        // 5: start+stop together in IDLE and RUN, then async reset mid-run
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("t5_idle_EN", EN, 1'b0);
        chk("t5_idle_A", A, 4'h0);
        start = 1'b1; cyc(); start = 1'b0;
        chk("t5_run_EN", EN, 1'b1);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t5_pause_A", A, 4'h0);
            chk("t5_pause_tick", tick, 1'b0);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t5_to_idle_EN", EN, 1'b0);
        start = 1'b1; cyc(); start = 1'b0;
        for (int a = 0; a < 9; a++) step(4'(a), 4'(a + 1), 1'b0);
        chk("t5_pre_rst_A", A, 4'd9);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst_A", A, 4'h0);
        chk("t5_arst_EN", EN, 1'b0);
        cyc(); rst = 1'b0;
        cyc();
        chk("t5_post_rst_EN", EN, 1'b0);

        // 6: switch to hold mid-step at 3, then pause
        start = 1'b1; cyc(); start = 1'b0;
        for (int a = 0; a < 3; a++) step(4'(a), 4'(a + 1), 1'b0);
        cyc();
        chk("t6_mid_A", A, 4'd3);
        mode = 2'b11;
        cyc(); cyc();
        chk("t6_hold_tick_lo", tick, 1'b0);
        cyc();
        chk("t6_hold_A", A, 4'd3);
        chk("t6_hold_tick", tick, 1'b1);
        chk("t6_hold_wrap", wrap, 1'b0);
        step(4'd3, 4'd3, 1'b0);
        step(4'd3, 4'd3, 1'b0);
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("t6_pause_EN0", EN, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            cyc();
`ifdef SCAN_BLINK_EN
            en_exp = ((i / 4) % 2 == 0);
`else
            en_exp = 1'b1;
`endif
            chk("t6_pause_EN", EN, en_exp);
            chk("t6_pause_A", A, 4'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
